// File: rtl/sram_bank_ring_ctrl_if.sv
// Bus bundle for sram_bank_ring_ctrl: write stream, read request/response, status.
// slave = controller side, master = DMA/read-engine side.
interface sram_bank_ring_ctrl_if #(
    parameter int AW = 10,
    parameter int DW = 128,
    parameter int NB = 3
);
    localparam int BW = $clog2(NB);

    logic [3:0]    mode_i;
    logic          data_sop_i;
    logic          data_eop_i;
    logic [DW-1:0] wdata_i;
    logic          wdata_vld_i;
    logic [AW-1:0] waddr_i;
    logic          wline_done_i;
    logic [AW-1:0] raddr_i;
    logic [BW-1:0] rbank_ofs_i;
    logic          raddr_vld_i;
    logic          rd_done_i;
    logic [DW-1:0] rdata_o;
    logic          rdata_vld_o;
    logic          rd_rej_o;
    logic          wr_drop_o;
    logic          rd_perr_o;
    logic [3:0]    sram_status_o;
    logic [BW-1:0] wbank_o;

    modport slave (
        input  mode_i, data_sop_i, data_eop_i, wdata_i, wdata_vld_i, waddr_i,
               wline_done_i, raddr_i, rbank_ofs_i, raddr_vld_i, rd_done_i,
        output rdata_o, rdata_vld_o, rd_rej_o, wr_drop_o, rd_perr_o,
               sram_status_o, wbank_o
    );

    modport master (
        output mode_i, data_sop_i, data_eop_i, wdata_i, wdata_vld_i, waddr_i,
               wline_done_i, raddr_i, rbank_ofs_i, raddr_vld_i, rd_done_i,
        input  rdata_o, rdata_vld_o, rd_rej_o, wr_drop_o, rd_perr_o,
               sram_status_o, wbank_o
    );
endinterface

// File: rtl/sram_bank_ring_ctrl.sv
// N-bank rotating line-buffer SRAM controller: one write bank fills while older banks are read.
// Define SRAM_PARITY_EN to store an even-parity bit per word and flag rd_perr_o on mismatch.
module sram_bank_ring_ctrl #(
    parameter int AW     = 10,
    parameter int DW     = 128,
    parameter int NB     = 3,
    parameter int RD_LAT = 1
) (
    input  logic                  SYS_CLK,
    input  logic                  SYS_RST,
    sram_bank_ring_ctrl_if.slave  bus
);
    localparam int BW    = $clog2(NB);
    localparam int DEPTH = 1 << AW;
`ifdef SRAM_PARITY_EN
    localparam int MW    = DW + 1;
`else
    localparam int MW    = DW;
`endif
    localparam logic [BW:0]   NB_X   = (BW+1)'(NB);
    localparam logic [BW-1:0] LAST_B = BW'(NB - 1);
    localparam logic [BW-1:0] WR_MAX = BW'(NB - 2);

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        WSRAM  = 4'b0010,
        RSRAM  = 4'b0100,
        WRSRAM = 4'b1000
    } state_t;

    state_t        state_q;
    logic [BW-1:0] wbank_q, rbase_q, fill_q;
    logic [MW-1:0] mem_q [NB][DEPTH];

    logic          cnn, fc, wr_ok, wr_en, rd_acc;
    logic [BW:0]   rsum;
    logic [BW-1:0] rbank;
    logic [MW-1:0] wword;
    logic          rd_rej_q, wr_drop_q;
    logic          s1_vld_q, out_vld;
    logic [MW-1:0] s1_word_q, out_word;

    function automatic logic [BW-1:0] bank_inc(input logic [BW-1:0] b);
        return (b == LAST_B) ? '0 : b + 1'b1;
    endfunction

    assign cnn   = |bus.mode_i[2:0];
    assign fc    = bus.mode_i[3];
    assign wr_ok = (state_q == WSRAM) || (state_q == WRSRAM);
    assign wr_en = bus.wdata_vld_i && wr_ok;

    // Strobes are single-cycle valids with no backpressure: a request not accepted in its
    // cycle is reported by a rd_rej_o / wr_drop_o pulse one cycle later and never retried.
    assign rsum   = {1'b0, rbase_q} + {1'b0, bus.rbank_ofs_i};
    assign rbank  = (rsum >= NB_X) ? BW'(rsum - NB_X) : rsum[BW-1:0];
    assign rd_acc = bus.raddr_vld_i &&
                    (((state_q == WRSRAM) && (bus.rbank_ofs_i <= WR_MAX)) ||
                     ((state_q == RSRAM)  && (bus.rbank_ofs_i <= LAST_B)));

`ifdef SRAM_PARITY_EN
    assign wword = {^bus.wdata_i, bus.wdata_i};
`else
    assign wword = bus.wdata_i;
`endif

    always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            state_q <= IDLE;
            wbank_q <= '0;
            rbase_q <= '0;
            fill_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.data_sop_i) begin
                    state_q <= WSRAM;
                    wbank_q <= '0;
                    rbase_q <= '0;
                    fill_q  <= '0;
                end
                WSRAM: begin
                    if (bus.wline_done_i) begin
                        wbank_q <= bank_inc(wbank_q);
                        if (fill_q != LAST_B) fill_q <= fill_q + 1'b1;
                    end
                    if (cnn && bus.wline_done_i && (fill_q == WR_MAX)) begin
                        state_q <= WRSRAM;
                        rbase_q <= '0;
                    end else if (fc && bus.data_eop_i) begin
                        state_q <= RSRAM;
                        rbase_q <= '0;
                    end
                end
                WRSRAM: begin
                    // Oldest readable bank is the one right after the new write bank.
                    if (bus.wline_done_i) begin
                        wbank_q <= bank_inc(wbank_q);
                        rbase_q <= bank_inc(bank_inc(wbank_q));
                        if (fill_q != LAST_B) fill_q <= fill_q + 1'b1;
                    end
                    if (bus.data_eop_i) state_q <= RSRAM;
                end
                RSRAM: if (bus.rd_done_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (wr_en) mem_q[wbank_q][bus.waddr_i] <= wword;
    end

    always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            s1_vld_q  <= 1'b0;
            s1_word_q <= '0;
            rd_rej_q  <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            s1_vld_q  <= rd_acc;
            if (rd_acc) s1_word_q <= mem_q[rbank][bus.raddr_i];
            rd_rej_q  <= bus.raddr_vld_i && !rd_acc;
            wr_drop_q <= bus.wdata_vld_i && !wr_ok;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic          s2_vld_q;
            logic [MW-1:0] s2_word_q;
            always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
                if (SYS_RST) begin
                    s2_vld_q  <= 1'b0;
                    s2_word_q <= '0;
                end else begin
                    s2_vld_q <= s1_vld_q;
                    if (s1_vld_q) s2_word_q <= s1_word_q;
                end
            end
            assign out_vld  = s2_vld_q;
            assign out_word = s2_word_q;
        end else begin : g_lat1
            assign out_vld  = s1_vld_q;
            assign out_word = s1_word_q;
        end
    endgenerate

    assign bus.rdata_o       = out_word[DW-1:0];
    assign bus.rdata_vld_o   = out_vld;
`ifdef SRAM_PARITY_EN
    assign bus.rd_perr_o     = out_vld && (out_word[DW] != ^out_word[DW-1:0]);
`else
    assign bus.rd_perr_o     = 1'b0;
`endif
    assign bus.rd_rej_o      = rd_rej_q;
    assign bus.wr_drop_o     = wr_drop_q;
    assign bus.sram_status_o = state_q;
    assign bus.wbank_o       = wbank_q;
endmodule

// File: tb/tb_sram_bank_ring_ctrl.sv
// Bench for sram_bank_ring_ctrl: RD_LAT=1 and RD_LAT=2 instances share one stimulus stream;
// read results are checked against a scoreboard of expected data and arrival cycles.
module tb_sram_bank_ring_ctrl;
    localparam int AW = 10;
    localparam int DW = 128;
    localparam int NB = 3;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_bank_ring_ctrl_if #(.AW(AW), .DW(DW), .NB(NB)) bus1 ();
    sram_bank_ring_ctrl_if #(.AW(AW), .DW(DW), .NB(NB)) bus2 ();

    assign bus2.mode_i       = bus1.mode_i;
    assign bus2.data_sop_i   = bus1.data_sop_i;
    assign bus2.data_eop_i   = bus1.data_eop_i;
    assign bus2.wdata_i      = bus1.wdata_i;
    assign bus2.wdata_vld_i  = bus1.wdata_vld_i;
    assign bus2.waddr_i      = bus1.waddr_i;
    assign bus2.wline_done_i = bus1.wline_done_i;
    assign bus2.raddr_i      = bus1.raddr_i;
    assign bus2.rbank_ofs_i  = bus1.rbank_ofs_i;
    assign bus2.raddr_vld_i  = bus1.raddr_vld_i;
    assign bus2.rd_done_i    = bus1.rd_done_i;

    sram_bank_ring_ctrl #(.AW(AW), .DW(DW), .NB(NB), .RD_LAT(1)) dut1 (
        .SYS_CLK(clk), .SYS_RST(rst), .bus(bus1));
    sram_bank_ring_ctrl #(.AW(AW), .DW(DW), .NB(NB), .RD_LAT(2)) dut2 (
        .SYS_CLK(clk), .SYS_RST(rst), .bus(bus2));

    logic [DW-1:0] ref_mem [NB][1 << AW];
    logic [DW-1:0] exp_q1[$], exp_q2[$];
    int            cyc_q1[$], cyc_q2[$], rej_q[$], drop_q[$];
    logic          perr_q1[$];
    logic [DW-1:0] last1 = '0, last2 = '0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus1.wdata_vld_i  = 1'b0;
        bus1.raddr_vld_i  = 1'b0;
        bus1.wline_done_i = 1'b0;
        bus1.data_sop_i   = 1'b0;
        bus1.data_eop_i   = 1'b0;
        bus1.rd_done_i    = 1'b0;
    endtask

    task automatic set_wr(input int bank, input int a, input bit done);
        logic [DW-1:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        ref_mem[bank][a]  = d;
        bus1.wdata_i      = d;
        bus1.waddr_i      = AW'(a);
        bus1.wdata_vld_i  = 1'b1;
        bus1.wline_done_i = done;
    endtask

    task automatic set_drop();
        bus1.wdata_i     = {$urandom, $urandom, $urandom, $urandom};
        bus1.waddr_i     = AW'($urandom_range(0, 15));
        bus1.wdata_vld_i = 1'b1;
        drop_q.push_back(cyc + 1);
    endtask

    task automatic set_rd(input int ofs, input int a, input bit acc, input int bank, input bit perr);
        bus1.rbank_ofs_i = 2'(ofs);
        bus1.raddr_i     = AW'(a);
        bus1.raddr_vld_i = 1'b1;
        if (acc) begin
            exp_q1.push_back(ref_mem[bank][a]);
            cyc_q1.push_back(cyc + 1);
            perr_q1.push_back(perr);
            exp_q2.push_back(ref_mem[bank][a]);
            cyc_q2.push_back(cyc + 2);
        end else begin
            rej_q.push_back(cyc + 1);
        end
    endtask

    always @(negedge clk) begin : mon1
        bit due;
        if (!rst) begin
            due = (cyc_q1.size() > 0) && (cyc_q1[0] == cyc);
            if (bus1.rdata_vld_o || due) begin
                chk("vld1", bus1.rdata_vld_o, due);
                if (bus1.rdata_vld_o && due) begin
                    chk("rdata1", bus1.rdata_o, exp_q1[0]);
                    chk("perr1", bus1.rd_perr_o, perr_q1[0]);
                    last1 = exp_q1[0];
                end
                if (due) begin
                    void'(exp_q1.pop_front());
                    void'(cyc_q1.pop_front());
                    void'(perr_q1.pop_front());
                end
            end else begin
                chk("hold1", bus1.rdata_o, last1);
            end
            due = (rej_q.size() > 0) && (rej_q[0] == cyc);
            if (bus1.rd_rej_o || due) begin
                chk("rd_rej", bus1.rd_rej_o, due);
                if (due) void'(rej_q.pop_front());
            end
            due = (drop_q.size() > 0) && (drop_q[0] == cyc);
            if (bus1.wr_drop_o || due) begin
                chk("wr_drop", bus1.wr_drop_o, due);
                if (due) void'(drop_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin : mon2
        bit due;
        if (!rst) begin
            due = (cyc_q2.size() > 0) && (cyc_q2[0] == cyc);
            if (bus2.rdata_vld_o || due) begin
                chk("vld2", bus2.rdata_vld_o, due);
                if (bus2.rdata_vld_o && due) begin
                    chk("rdata2", bus2.rdata_o, exp_q2[0]);
                    last2 = exp_q2[0];
                end
                if (due) begin
                    void'(exp_q2.pop_front());
                    void'(cyc_q2.pop_front());
                end
            end else begin
                chk("hold2", bus2.rdata_o, last2);
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus1.mode_i = 4'b0000;
        bus1.wdata_i = '0;
        bus1.waddr_i = '0;
        bus1.raddr_i = '0;
        bus1.rbank_ofs_i = '0;
        bus1.wdata_vld_i = 1'b0;
        bus1.raddr_vld_i = 1'b0;
        bus1.wline_done_i = 1'b0;
        bus1.data_sop_i = 1'b0;
        bus1.data_eop_i = 1'b0;
        bus1.rd_done_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_status", bus1.sram_status_o, 4'b0001);
        chk("rst_wbank", bus1.wbank_o, 0);
        chk("rst_rdata1", bus1.rdata_o, 0);
        chk("rst_rdata2", bus2.rdata_o, 0);
        chk("rst_vld1", bus1.rdata_vld_o, 0);

        set_drop();
        set_rd(0, 0, 0, 0, 0);
        step();

        // cnn frame: two lines fill banks 0 and 1, then overlap write/read
        bus1.mode_i = 4'b0001;
        bus1.data_sop_i = 1'b1;
        step();
        chk("sop_status", bus1.sram_status_o, 4'b0010);
        chk("sop_wbank", bus1.wbank_o, 0);
        for (int a = 0; a < 6; a++) begin
            set_wr(0, a, a == 5);
            step();
        end
        chk("line0_wbank", bus1.wbank_o, 1);
        chk("line0_status", bus1.sram_status_o, 4'b0010);
        for (int a = 0; a < 6; a++) begin
            set_wr(1, a, 1'b0);
            step();
        end
        bus1.wline_done_i = 1'b1;
        step();
        chk("wr_status", bus1.sram_status_o, 4'b1000);
        chk("wr_wbank", bus1.wbank_o, 2);
        set_rd(0, 3, 1, 0, 0);
        step();
        for (int a = 0; a < 4; a++) begin
            set_wr(2, a, 1'b0);
            set_rd(1, a, 1, 1, 0);
            step();
        end
        bus1.wline_done_i = 1'b1;
        step();
        chk("rot_wbank", bus1.wbank_o, 0);
        chk("rot_status", bus1.sram_status_o, 4'b1000);
        set_rd(0, 0, 1, 1, 0);
        step();
        set_rd(1, 1, 1, 2, 0);
        step();
        set_rd(2, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            set_rd(i % 2, i, 1, (i % 2 == 0) ? 1 : 2, 0);
            step();
        end
        repeat (4) step();

        // reset mid-WRSRAM with a read on the bus: it must be aborted
        bus1.raddr_vld_i = 1'b1;
        bus1.rbank_ofs_i = '0;
        bus1.raddr_i = AW'(1);
        rst = 1'b1;
        #1;
        chk("midrst_status", bus1.sram_status_o, 4'b0001);
        step();
        chk("midrst_wbank", bus1.wbank_o, 0);
        chk("midrst_vld1", bus1.rdata_vld_o, 0);
        chk("midrst_vld2", bus2.rdata_vld_o, 0);
        chk("midrst_rej", bus1.rd_rej_o, 0);
        chk("midrst_rdata", bus1.rdata_o, 0);
        last1 = '0;
        last2 = '0;
        rst = 1'b0;
        step();

        // full-connect frame: one bank written, then read phase
        bus1.mode_i = 4'b1000;
        bus1.data_sop_i = 1'b1;
        step();
        chk("fc_status", bus1.sram_status_o, 4'b0010);
        for (int a = 0; a < 8; a++) begin
            set_wr(0, a, 1'b0);
            step();
        end
        bus1.data_eop_i = 1'b1;
        step();
        chk("eop_status", bus1.sram_status_o, 4'b0100);
        set_drop();
        step();
        set_rd(0, 7, 1, 0, 0);
        step();
        set_rd(2, 1, 1, 2, 0);
        step();
        set_rd(3, 0, 0, 0, 0);
        step();
`ifdef SRAM_PARITY_EN
        dut1.mem_q[1][5][0] = ~dut1.mem_q[1][5][0];
        dut2.mem_q[1][5][0] = ~dut2.mem_q[1][5][0];
        ref_mem[1][5][0] = ~ref_mem[1][5][0];
        set_rd(1, 5, 1, 1, 1);
`else
        set_rd(1, 5, 1, 1, 0);
`endif
        step();
        bus1.data_sop_i = 1'b1;
        step();
        chk("sop_ignored", bus1.sram_status_o, 4'b0100);
        bus1.rd_done_i = 1'b1;
        step();
        chk("rd_done_status", bus1.sram_status_o, 4'b0001);
        repeat (4) step();
        chk("pending", cyc_q1.size() + cyc_q2.size() + rej_q.size() + drop_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
